// File: rtl/interp_pkg.sv
// ---------------------------------------------------------------------------
// interp_pkg
// Shared definitions for the pilot-interpolation controller and the
// interpolation datapath (interpolation_top):
//   - state_e    : controller FSM state encoding
//   - NUM_STEPS  : number of output subcarrier pairs per sequence
//   - sel_t      : one row of adder-operand / output-mux select codes
//   - sel_lookup : 8-entry select-code table (PRIME0, PRIME1, step0..step5)
// ---------------------------------------------------------------------------
package interp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRIME0 = 3'd1,
    ST_PRIME1 = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int NUM_STEPS = 6;

  // Table row indices: the priming rows come first, step k lives at row k+2.
  localparam logic [2:0] TBL_PRIME0 = 3'd0;
  localparam logic [2:0] TBL_PRIME1 = 3'd1;
  localparam logic [2:0] TBL_STEP0  = 3'd2;

  typedef struct packed {
    logic [1:0] s1a;
    logic [1:0] s1b;
    logic [1:0] s2a;
    logic [1:0] s2b;
    logic [1:0] s_h1;
    logic [1:0] s_h2;
  } sel_t;

  // Select codes consumed by both the controller and the datapath.
  // Field order: s1a, s1b, s2a, s2b, s_h1, s_h2.
  function automatic sel_t sel_lookup(input logic [2:0] idx);
    sel_t v;
    case (idx)
      3'd0:    v = {2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0}; // PRIME0: h6, 2*h6
      3'd1:    v = {2'd2, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0}; // PRIME1: 5*h9
      3'd2:    v = {2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd2}; // step0
      3'd3:    v = {2'd1, 2'd0, 2'd2, 2'd1, 2'd2, 2'd1}; // step1
      3'd4:    v = {2'd2, 2'd1, 2'd0, 2'd3, 2'd3, 2'd0}; // step2
      3'd5:    v = {2'd3, 2'd2, 2'd1, 2'd1, 2'd1, 2'd3}; // step3
      3'd6:    v = {2'd1, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2}; // step4
      3'd7:    v = {2'd0, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1}; // step5
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/interp_ctrl.sv
// ---------------------------------------------------------------------------
// interp_ctrl
// Sequencer for the pilot-interpolation datapath. After a start pulse it
// primes the datapath registers (PRIME0, PRIME1), then walks six output
// steps, presenting one subcarrier pair per step under a valid/ready
// handshake, and finally pulses done.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   start              : one-cycle start pulse (pilots stable until done)
//   out_ready          : downstream accepts the current output pair
//   s1a,s1b,s2a,s2b    : adder operand mux selects
//   s_h1,s_h2          : output mux selects
//   en_reg_h6/2h6/5h9  : datapath register enables
//   out_valid,out_idx  : output pair valid, index of h_eqlz_1 (h_eqlz_2 = +1)
//   busy, done         : sequence in progress / one-cycle completion pulse
//
// Build option
//   INTERP_START_QUEUE_EN : when defined, one start arriving while busy is
//                           remembered and launched straight from DONE.
// ---------------------------------------------------------------------------
import interp_pkg::*;

module interp_ctrl #(
  parameter int SC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            out_ready,
  output logic [1:0]      s1a,
  output logic [1:0]      s1b,
  output logic [1:0]      s2a,
  output logic [1:0]      s2b,
  output logic [1:0]      s_h1,
  output logic [1:0]      s_h2,
  output logic            en_reg_h6,
  output logic            en_reg_2h6,
  output logic            en_reg_5h9,
  output logic            out_valid,
  output logic [SC_W-1:0] out_idx,
  output logic            busy,
  output logic            done
);

  state_e     r_state;
  logic [2:0] r_k;
  sel_t       r_sel;
  logic       w_launch;
  logic       w_accept;

`ifdef INTERP_START_QUEUE_EN
  logic       r_pending;

  // One-deep start queue: capture a start seen while busy, clear on launch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else if ((r_state == ST_DONE) && w_launch) begin
      r_pending <= 1'b0;
    end else if (start && busy) begin
      r_pending <= 1'b1;
    end else begin
      r_pending <= r_pending;
    end
  end

  // A new sequence may begin from IDLE, or directly from DONE.
  always_comb begin
    w_launch = ((r_state == ST_IDLE) && start) ||
               ((r_state == ST_DONE) && (start || r_pending));
  end
`else
  // A new sequence may begin from IDLE, or directly from DONE.
  always_comb begin
    w_launch = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
  end
`endif

  assign w_accept = out_valid && out_ready;

  // Selects are held in one packed register and fanned out unchanged.
  assign s1a  = r_sel.s1a;
  assign s1b  = r_sel.s1b;
  assign s2a  = r_sel.s2a;
  assign s2b  = r_sel.s2b;
  assign s_h1 = r_sel.s_h1;
  assign s_h2 = r_sel.s_h2;

  // Controller FSM: every output is loaded with the value for the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_k        <= 3'd0;
      r_sel      <= '0;
      en_reg_h6  <= 1'b0;
      en_reg_2h6 <= 1'b0;
      en_reg_5h9 <= 1'b0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Enables and done are single-cycle; only the priming/DONE entries raise them.
      en_reg_h6  <= 1'b0;
      en_reg_2h6 <= 1'b0;
      en_reg_5h9 <= 1'b0;
      done       <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_k       <= 3'd0;
          out_valid <= 1'b0;
          out_idx   <= '0;
          if (w_launch) begin
            r_state    <= ST_PRIME0;
            r_sel      <= sel_lookup(TBL_PRIME0);
            en_reg_h6  <= 1'b1;
            en_reg_2h6 <= 1'b1;
            busy       <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            busy    <= 1'b0;
          end
        end
        ST_PRIME0: begin
          r_state    <= ST_PRIME1;
          r_sel      <= sel_lookup(TBL_PRIME1);
          en_reg_5h9 <= 1'b1;
          busy       <= 1'b1;
        end
        ST_PRIME1: begin
          r_state   <= ST_RUN;
          r_k       <= 3'd0;
          r_sel     <= sel_lookup(TBL_STEP0);
          out_valid <= 1'b1;
          out_idx   <= '0;
          busy      <= 1'b1;
        end
        ST_RUN: begin
          if (w_accept) begin
            if (r_k == 3'(NUM_STEPS - 1)) begin
              r_state   <= ST_DONE;
              r_k       <= 3'd0;
              r_sel     <= '0;
              out_valid <= 1'b0;
              out_idx   <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              r_k     <= r_k + 3'd1;
              // Row of step k+1 is (k+1)+2.
              r_sel   <= sel_lookup(r_k + 3'd3);
              // Index of the first subcarrier of pair k+1 is 2*(k+1).
              out_idx <= SC_W'({r_k + 3'd1, 1'b0});
            end
          end else begin
            // Stall: hold everything as presented.
            r_k     <= r_k;
            r_sel   <= r_sel;
            out_idx <= out_idx;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_k       <= 3'd0;
          r_sel     <= '0;
          out_valid <= 1'b0;
          out_idx   <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_interp_ctrl
// Self-checking bench for interp_ctrl. A cycle-level reference model tracks
// the position of the current sequence in its schedule (0 idle, 1 PRIME0,
// 2 PRIME1, 3..8 output pairs, 9 done) and predicts every output each cycle.
// Honors INTERP_START_QUEUE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_interp_ctrl;

  localparam int SC_W = 4;
`ifdef INTERP_START_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic [1:0] s1a, s1b, s2a, s2b, s_h1, s_h2;
  logic en_reg_h6, en_reg_2h6, en_reg_5h9, out_valid, busy, done;
  logic [SC_W-1:0] out_idx;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pos = 0;
  bit pend = 1'b0;
  int done_seen = 0;
  logic [11:0] tbl [8];

  always #5 clk = ~clk;

  interp_ctrl #(.SC_W(SC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .out_ready(out_ready),
    .s1a(s1a), .s1b(s1b), .s2a(s2a), .s2b(s2b), .s_h1(s_h1), .s_h2(s_h2),
    .en_reg_h6(en_reg_h6), .en_reg_2h6(en_reg_2h6), .en_reg_5h9(en_reg_5h9),
    .out_valid(out_valid), .out_idx(out_idx), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance the schedule model by one clock with the inputs of that cycle.
  task automatic model_next(input bit r, input bit s, input bit rd);
    bit launch;
    if (r) begin
      pos  = 0;
      pend = 1'b0;
    end else begin
      launch = (pos == 0 && s) || (pos == 9 && (s || (QUEUE && pend)));
      if (QUEUE && pos >= 1 && pos <= 8 && s) pend = 1'b1;
      if (pos == 0 || pos == 9) begin
        if (launch) begin
          pos  = 1;
          pend = 1'b0;
        end else begin
          pos = 0;
        end
      end else if (pos <= 2) begin
        pos++;
      end else if (rd) begin
        pos++;
      end
    end
  endtask

  task automatic check_all();
    logic [11:0] exp_sel;
    bit vld;
    exp_sel = (pos >= 1 && pos <= 8) ? tbl[pos-1] : 12'd0;
    vld = (pos >= 3 && pos <= 8);
    chk("selects", {20'd0, s1a, s1b, s2a, s2b, s_h1, s_h2}, {20'd0, exp_sel});
    chk("enables", {29'd0, en_reg_h6, en_reg_2h6, en_reg_5h9},
        {29'd0, (pos == 1), (pos == 1), (pos == 2)});
    chk("out_valid", {31'd0, out_valid}, {31'd0, vld});
    chk("out_idx", {28'd0, out_idx}, vld ? 32'(2 * (pos - 3)) : 32'd0);
    chk("busy", {31'd0, busy}, {31'd0, (pos >= 1 && pos <= 8)});
    chk("done", {31'd0, done}, {31'd0, (pos == 9)});
    if (done === 1'b1) done_seen++;
  endtask

  task automatic step(input bit r, input bit s, input bit rd);
    rst = r; start = s; out_ready = rd;
    @(posedge clk);
    cyc++;
    model_next(r, s, rd);
    #1;
    check_all();
  endtask

  task automatic wait_idx(input int idx);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1 && out_idx === SC_W'(idx)) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 1'b1);
    end
    chk("wait_idx_timeout", {31'd0, found}, 32'd1);
  endtask

  task automatic wait_done();
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 1'b1);
    end
    chk("wait_done_timeout", {31'd0, found}, 32'd1);
  endtask

  initial begin
    int t0;
    int d0;
    tbl[0] = {2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
    tbl[1] = {2'd2, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    tbl[2] = {2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd2};
    tbl[3] = {2'd1, 2'd0, 2'd2, 2'd1, 2'd2, 2'd1};
    tbl[4] = {2'd2, 2'd1, 2'd0, 2'd3, 2'd3, 2'd0};
    tbl[5] = {2'd3, 2'd2, 2'd1, 2'd1, 2'd1, 2'd3};
    tbl[6] = {2'd1, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2};
    tbl[7] = {2'd0, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1};

    // Reset: all outputs zero; reset wins over a simultaneous start.
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Nominal sequence with out_ready held high: latencies 3 and 9.
    t0 = cyc;
    step(1'b0, 1'b1, 1'b1);
    chk("lat_prime0", {31'd0, en_reg_h6}, 32'd1);
    wait_idx(0);
    chk("lat_first_valid", 32'(cyc - t0), 32'd3);
    wait_done();
    chk("lat_done", 32'(cyc - t0), 32'd9);
    step(1'b0, 1'b0, 1'b1);

    // Three-cycle stall at k=2: sequence stretches by three cycles.
    t0 = cyc;
    step(1'b0, 1'b1, 1'b1);
    wait_idx(4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    chk("stall_idx_held", {28'd0, out_idx}, 32'd4);
    wait_done();
    chk("lat_done_stall", 32'(cyc - t0), 32'd12);
    step(1'b0, 1'b0, 1'b1);

    // Reset at k=3 aborts without done; a new start then runs from idx 0.
    d0 = done_seen;
    step(1'b0, 1'b1, 1'b1);
    wait_idx(6);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1);
    chk("abort_no_done", 32'(done_seen - d0), 32'd0);
    t0 = cyc;
    step(1'b0, 1'b1, 1'b1);
    wait_done();
    chk("restart_lat_done", 32'(cyc - t0), 32'd9);
    step(1'b0, 1'b0, 1'b1);

    // Second start at k=1: dropped, or queued with INTERP_START_QUEUE_EN.
    d0 = done_seen;
    step(1'b0, 1'b1, 1'b1);
    wait_idx(2);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1);
    chk("busy_start_done_count", 32'(done_seen - d0), QUEUE ? 32'd2 : 32'd1);

    // Start coincident with done: back-to-back sequences.
    d0 = done_seen;
    step(1'b0, 1'b1, 1'b1);
    wait_done();
    step(1'b0, 1'b1, 1'b1);
    chk("b2b_prime0", {31'd0, en_reg_h6}, 32'd1);
    t0 = cyc - 1;
    wait_done();
    chk("b2b_lat_done", 32'(cyc - t0), 32'd9);
    chk("b2b_done_count", 32'(done_seen - d0), 32'd2);
    step(1'b0, 1'b0, 1'b1);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(99) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
